bilinear_sampler: RTL and testbench

BILINEAR_SAMPLER -- requirements
Module: bilinear_sampler

---
 rtl/bilinear_sampler.sv | 153 +++++++++++++++
 tb/tb_bilinear_sampler.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/bilinear_sampler.sv
// Walks 8 radius-2 points around a centre pixel. For each point it fetches the 2x2 neighbourhood
// and hands the pixels and the Q16.8 coordinate to a downstream interpolator.
module bilinear_sampler #(
  parameter int WIDTH  = 8,
  parameter int FIXED  = 24,
  parameter int IMG_W  = 64,
  parameter int ADDR_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [WIDTH-1:0]  i_cx,
  input  logic [WIDTH-1:0]  i_cy,
  output logic              o_busy,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [WIDTH-1:0]  i_rd_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [WIDTH-1:0]  o_pixel_00,
  output logic [WIDTH-1:0]  o_pixel_01,
  output logic [WIDTH-1:0]  o_pixel_10,
  output logic [WIDTH-1:0]  o_pixel_11,
  output logic [WIDTH-1:0]  o_x_ori,
  output logic [WIDTH-1:0]  o_y_ori,
  output logic [FIXED-1:0]  o_x_ne,
  output logic [FIXED-1:0]  o_y_ne,
  output logic [2:0]        o_pt_idx,
  output logic              o_last,
  output logic              o_done
);

  localparam int CW = WIDTH + 8;

  typedef enum logic [3:0] {
    S_IDLE, S_CALC, S_RD0, S_RD1, S_RD2, S_RD3, S_WAIT, S_OUT, S_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   cx_reg, cy_reg;
  logic [2:0]         k_reg;
  logic [CW-1:0]      x_ne_reg, y_ne_reg;
  logic [CW-1:0]      x_ne_next, y_ne_next;
  logic signed [15:0] dx, dy;
  logic [WIDTH-1:0]   pixel_reg [4];
  logic [ADDR_W-1:0]  base_addr;

  // Radius-2 circle in Q8.8; 362 is 2*cos(45deg) rounded.
  always_comb begin
    dx = 16'sd0;
    dy = 16'sd0;
    case (k_reg)
      3'd0: begin dx =  16'sd512; dy =  16'sd0;   end
      3'd1: begin dx =  16'sd362; dy =  16'sd362; end
      3'd2: begin dx =  16'sd0;   dy =  16'sd512; end
      3'd3: begin dx = -16'sd362; dy =  16'sd362; end
      3'd4: begin dx = -16'sd512; dy =  16'sd0;   end
      3'd5: begin dx = -16'sd362; dy = -16'sd362; end
      3'd6: begin dx =  16'sd0;   dy = -16'sd512; end
      default: begin dx = 16'sd362; dy = -16'sd362; end
    endcase
  end

  assign x_ne_next = {cx_reg, 8'd0} + CW'(dx);
  assign y_ne_next = {cy_reg, 8'd0} + CW'(dy);
  assign base_addr = ADDR_W'(y_ne_reg[CW-1:8]) * ADDR_W'(IMG_W) + ADDR_W'(x_ne_reg[CW-1:8]);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= S_IDLE;
      cx_reg    <= '0;
      cy_reg    <= '0;
      k_reg     <= '0;
      x_ne_reg  <= '0;
      y_ne_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && i_start) begin
        cx_reg <= i_cx;
        cy_reg <= i_cy;
        k_reg  <= '0;
      end
      if (state_reg == S_CALC) begin
        x_ne_reg <= x_ne_next;
        y_ne_reg <= y_ne_next;
      end
      if (state_reg == S_OUT && i_ready)
        k_reg <= k_reg + 3'd1;
    end
  end

  // Read data lags the strobe by one cycle, so pixel gi lands on the edge leaving RD1+gi.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pix
      localparam logic [3:0] CAP = 4'(S_RD1) + 4'(gi);
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
          pixel_reg[gi] <= '0;
        else if (4'(state_reg) == CAP)
          pixel_reg[gi] <= i_rd_data;
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    o_rd_en    = 1'b0;
    o_rd_addr  = '0;
    case (state_reg)
      S_IDLE: if (i_start) state_next = S_CALC;
      S_CALC: state_next = S_RD0;
      S_RD0: begin
        state_next = S_RD1;
        o_rd_en    = 1'b1;
        o_rd_addr  = base_addr;
      end
      S_RD1: begin
        state_next = S_RD2;
        o_rd_en    = 1'b1;
        o_rd_addr  = base_addr + ADDR_W'(1);
      end
      S_RD2: begin
        state_next = S_RD3;
        o_rd_en    = 1'b1;
        o_rd_addr  = base_addr + ADDR_W'(IMG_W);
      end
      S_RD3: begin
        state_next = S_WAIT;
        o_rd_en    = 1'b1;
        o_rd_addr  = base_addr + ADDR_W'(IMG_W + 1);
      end
      S_WAIT: state_next = S_OUT;
      S_OUT:  if (i_ready) state_next = (k_reg == 3'd7) ? S_DONE : S_CALC;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign o_busy     = (state_reg != S_IDLE);
  assign o_valid    = (state_reg == S_OUT);
  assign o_last     = (state_reg == S_OUT) && (k_reg == 3'd7);
  assign o_done     = (state_reg == S_DONE);
  assign o_pt_idx   = k_reg;
  assign o_x_ne     = FIXED'(x_ne_reg);
  assign o_y_ne     = FIXED'(y_ne_reg);
  assign o_x_ori    = x_ne_reg[CW-1:8];
  assign o_y_ori    = y_ne_reg[CW-1:8];
  assign o_pixel_00 = pixel_reg[0];
  assign o_pixel_01 = pixel_reg[1];
  assign o_pixel_10 = pixel_reg[2];
  assign o_pixel_11 = pixel_reg[3];

endmodule

// File: tb/tb_bilinear_sampler.sv
// Directed bench for bilinear_sampler: centre (10,10) on a 64-wide image, memory returns address[7:0].
module tb_bilinear_sampler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cx = 8'd0, cy = 8'd0;
  logic        busy, rd_en, valid, last, done;
  logic        ready = 1'b1;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data = 8'd0;
  logic [7:0]  p00, p01, p10, p11, x_ori, y_ori;
  logic [23:0] x_ne, y_ne;
  logic [2:0]  pt_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0;

  // Hand-computed for centre (10,10): Q16.8 coordinates, integer corners, A = y_ori*64 + x_ori.
  int exp_xne [8] = '{32'h0C00, 32'h0B6A, 32'h0A00, 32'h0896, 32'h0800, 32'h0896, 32'h0A00, 32'h0B6A};
  int exp_yne [8] = '{32'h0A00, 32'h0B6A, 32'h0C00, 32'h0B6A, 32'h0A00, 32'h0896, 32'h0800, 32'h0896};
  int exp_xo  [8] = '{12, 11, 10, 8, 8, 8, 10, 11};
  int exp_yo  [8] = '{10, 11, 12, 11, 10, 8, 8, 8};
  int exp_a   [8] = '{652, 715, 778, 712, 648, 520, 522, 523};
  int offs    [4] = '{0, 1, 64, 65};

  bilinear_sampler #(.WIDTH(8), .FIXED(24), .IMG_W(64), .ADDR_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_cx(cx), .i_cy(cy),
    .o_busy(busy), .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_valid(valid), .i_ready(ready),
    .o_pixel_00(p00), .o_pixel_01(p01), .o_pixel_10(p10), .o_pixel_11(p11),
    .o_x_ori(x_ori), .o_y_ori(y_ori), .o_x_ne(x_ne), .o_y_ne(y_ne),
    .o_pt_idx(pt_idx), .o_last(last), .o_done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_data <= rd_addr[7:0];
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_rd_en"}, 32'(rd_en), 0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_last"}, 32'(last), 0);
    chk({tag, "_pt_idx"}, 32'(pt_idx), 0);
    chk({tag, "_x_ne"}, 32'(x_ne), 0);
    chk({tag, "_pix00"}, 32'(p00), 0);
  endtask

  // Entered in the CALC cycle of point k; leaves in the cycle after the handshake edge.
  task automatic do_point(input int k, input int stall, input bit poke);
    chk("calc_rd_en", 32'(rd_en), 0);
    chk("calc_valid", 32'(valid), 0);
    if (poke) begin start = 1'b1; cx = 8'd30; cy = 8'd30; end
    step;
    start = 1'b0;
    for (int r = 0; r < 4; r++) begin
      chk($sformatf("rd_en_p%0d_r%0d", k, r), 32'(rd_en), 1);
      chk($sformatf("rd_addr_p%0d_r%0d", k, r), 32'(rd_addr), 32'(exp_a[k] + offs[r]));
      step;
    end
    chk("wait_rd_en", 32'(rd_en), 0);
    chk("wait_valid", 32'(valid), 0);
    if (stall > 0) ready = 1'b0;
    step;
    for (int s = 0; s <= stall; s++) begin
      chk($sformatf("valid_p%0d_s%0d", k, s), 32'(valid), 1);
      chk("out_rd_en", 32'(rd_en), 0);
      chk("pt_idx", 32'(pt_idx), 32'(k));
      chk("last", 32'(last), (k == 7) ? 1 : 0);
      chk("done_in_out", 32'(done), 0);
      chk($sformatf("x_ne_p%0d", k), 32'(x_ne), exp_xne[k]);
      chk($sformatf("y_ne_p%0d", k), 32'(y_ne), exp_yne[k]);
      chk("x_ori", 32'(x_ori), exp_xo[k]);
      chk("y_ori", 32'(y_ori), exp_yo[k]);
      chk("pix00", 32'(p00), (exp_a[k] + offs[0]) & 255);
      chk("pix01", 32'(p01), (exp_a[k] + offs[1]) & 255);
      chk("pix10", 32'(p10), (exp_a[k] + offs[2]) & 255);
      chk("pix11", 32'(p11), (exp_a[k] + offs[3]) & 255);
      if (s == stall) ready = 1'b1;
      step;
    end
  endtask

  task automatic run_seq(input int stall_pt, input int poke_pt, input int exp_cycles);
    cx = 8'd10; cy = 8'd10; start = 1'b1;
    step;
    start = 1'b0;
    t0 = cyc;
    chk("busy_after_start", 32'(busy), 1);
    for (int k = 0; k < 8; k++)
      do_point(k, (k == stall_pt) ? 5 : 0, (k == poke_pt));
    chk("done_pulse", 32'(done), 1);
    chk("done_busy", 32'(busy), 1);
    step;
    chk("idle_done", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("seq_cycles", 32'(cyc - t0), 32'(exp_cycles));
    step;
    chk("done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    step; step;
    chk_zero("reset");
    rst = 1'b0;
    // Start is raised right after release so the first edge must accept it.
    run_seq(-1, -1, 57);
    run_seq(2, 1, 62);

    // Reset during RD2 of point 4.
    cx = 8'd10; cy = 8'd10; start = 1'b1;
    step;
    start = 1'b0;
    for (int k = 0; k < 4; k++) do_point(k, 0, 1'b0);
    step; step; step;
    chk("rd2_addr_p4", 32'(rd_addr), 712);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    step;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("post_rst_quiet_%0d", i), {30'd0, rd_en, done}, 0);
      step;
    end
    run_seq(-1, -1, 57);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
